// File: rtl/sram_arb_pkg.sv
// Shared types and default parameters for the two-master SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Lowest write-protected address for master 1 (optional protection feature).
  localparam logic [ADDR_W_DEF-1:0] PROT_BASE_DEF = 8'hF0;

  // Transaction sequencer states: one SRAM transaction every four cycles.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ACK    = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic. Purely combinational; the pointer
// register lives in the parent. last_gnt = index of the previous winner.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // One-hot grant: a lone requester wins, contention goes to the master
  // that did not win last time.
  always_comb begin
    // NOTE: gnt gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/sram_arb2.sv
// Two-master round-robin arbiter and sequencer for a single-port SRAM with
// a registered read address. Each transaction walks IDLE -> ACCESS -> RESP
// -> ACK, so a request first seen in IDLE at cycle t is acked at cycle t+3.
// The SRAM port is driven only during ACCESS and is zero otherwise.
//
// Optional feature, macro SRAM_ARB_WPROT_EN: adds output m1_err; master 1
// writes at or above PROT_BASE run the full sequence but never raise SWRITE,
// and m1_err is reported alongside m1_ack.
module sram_arb2
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef SRAM_ARB_WPROT_EN
  ,
  parameter logic [ADDR_W-1:0] PROT_BASE = PROT_BASE_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef SRAM_ARB_WPROT_EN
  output logic              m1_err,
`endif

  output logic [ADDR_W-1:0] saddr,
  output logic [DATA_W-1:0] sdatain,
  output logic              SWRITE,
  input  logic [DATA_W-1:0] srdataout
);

  state_t state;
  logic   last_gnt;   // 1 = master 1 won the previous grant
  logic   cur_m;      // winner of the transaction in flight
  logic   cur_we;     // transaction in flight is a write
  logic   cur_err;    // transaction in flight is a blocked protected write
  logic [1:0] gnt;

  rr_arb2 u_arb (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );

  // Winner's request fields, selected by the one-hot grant.
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              prot_hit;

  assign win_we    = gnt[1] ? m1_we    : m0_we;
  assign win_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign win_wdata = gnt[1] ? m1_wdata : m0_wdata;

`ifdef SRAM_ARB_WPROT_EN
  assign prot_hit = gnt[1] & m1_we & (m1_addr >= PROT_BASE);
`else
  assign prot_hit = 1'b0;
`endif

  // Sequencer: grant and latch in IDLE, drive the SRAM in ACCESS, capture
  // read data and raise the winner's ack in RESP, hold ack for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every register, including the SRAM port and read data, is
      // assigned with <= so all of them see pre-edge values of each other.
      state    <= IDLE;
      last_gnt <= 1'b1;
      cur_m    <= 1'b0;
      cur_we   <= 1'b0;
      cur_err  <= 1'b0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      saddr    <= '0;
      sdatain  <= '0;
      SWRITE   <= 1'b0;
`ifdef SRAM_ARB_WPROT_EN
      m1_err   <= 1'b0;
`endif
    end else begin
      // Acks (and the error flag) are single-cycle pulses.
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
`ifdef SRAM_ARB_WPROT_EN
      m1_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|gnt) begin
            last_gnt <= gnt[1];
            cur_m    <= gnt[1];
            cur_we   <= win_we;
            cur_err  <= prot_hit;
            saddr    <= win_addr;
            sdatain  <= win_wdata;
            SWRITE   <= win_we & ~prot_hit;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          // The SRAM samples the port at this edge; release it afterwards.
          saddr   <= '0;
          sdatain <= '0;
          SWRITE  <= 1'b0;
          state   <= RESP;
        end
        RESP: begin
          if (!cur_we) begin
            if (cur_m) m1_rdata <= srdataout;
            else       m0_rdata <= srdataout;
          end
          if (cur_m) m1_ack <= 1'b1;
          else       m0_ack <= 1'b1;
`ifdef SRAM_ARB_WPROT_EN
          m1_err <= cur_m & cur_err;
`endif
          state <= ACK;
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arb2.sv
// Directed bench for sram_arb2 with a behavioural 256x8 SRAM that has a
// registered read address. Exercises reset, round-robin contention, write
// then read-back, reset during a read, and the optional write protection.
module tb_sram_arb2;

  logic       clk;
  logic       rst;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] saddr, sdatain, srdataout;
  logic       SWRITE;
`ifdef SRAM_ARB_WPROT_EN
  logic       m1_err;
`endif

  int tests = 0;
  int fails = 0;

  sram_arb2 dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_ack    (m0_ack),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_ack    (m1_ack),
    .m1_rdata  (m1_rdata),
`ifdef SRAM_ARB_WPROT_EN
    .m1_err    (m1_err),
`endif
    .saddr     (saddr),
    .sdatain   (sdatain),
    .SWRITE    (SWRITE),
    .srdataout (srdataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: write at the edge, registered address, data from that address.
  logic [7:0] mem [0:255];
  logic [7:0] sram_areg;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h01] = 8'h5A;
    mem[8'h02] = 8'hC3;
    mem[8'h20] = 8'h77;
    mem[8'hF4] = 8'h99;
    sram_areg  = 8'h00;
  end
  always @(posedge clk) begin
    if (SWRITE === 1'b1) mem[saddr] <= sdatain;
    sram_areg <= saddr;
  end
  assign srdataout = mem[sram_areg];

  // Protocol watch: a master may only drop req in its ack cycle (or in reset).
  logic m0_req_d = 1'b0, m1_req_d = 1'b0;
  always @(posedge clk) begin
    if (rst === 1'b0 && m0_req_d && !m0_req && m0_ack !== 1'b1) begin
      fails = fails + 1;
      $error("FAIL m0_req_drop: req dropped with ack=%0b, required ack=1", m0_ack);
    end
    if (rst === 1'b0 && m1_req_d && !m1_req && m1_ack !== 1'b1) begin
      fails = fails + 1;
      $error("FAIL m1_req_drop: req dropped with ack=%0b, required ack=1", m1_ack);
    end
    m0_req_d <= m0_req;
    m1_req_d <= m1_req;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the last run_txn call.
  int         lat, wr_cycles, other_ack;
  logic [7:0] wr_addr, wr_data, rd;
  logic       err;

  // One transaction from an IDLE cycle; returns to the next IDLE cycle.
  task automatic run_txn(input bit m, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata);
    if (m) begin
      m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1;
    end
    lat = -1; wr_cycles = 0; other_ack = 0; rd = 8'hxx; err = 1'b0;
    wr_addr = 8'h00; wr_data = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (SWRITE === 1'b1) begin
        wr_cycles++; wr_addr = saddr; wr_data = sdatain;
      end
      if ((m ? m0_ack : m1_ack) === 1'b1) other_ack++;
      if ((m ? m1_ack : m0_ack) === 1'b1) begin
        lat = i;
        rd  = m ? m1_rdata : m0_rdata;
`ifdef SRAM_ARB_WPROT_EN
        err = m1_err;
`endif
        break;
      end
    end
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
    tick();
  endtask

  int ack_who[$];
  int ack_t[$];
  int n0, n1, both, sw;
  logic [7:0] r0, r1;

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;

    // Reset held for two cycles.
    tick();
    tick();
    check("rst_m0_ack",   {31'd0, m0_ack}, 32'd0);
    check("rst_m1_ack",   {31'd0, m1_ack}, 32'd0);
    check("rst_m0_rdata", {24'd0, m0_rdata}, 32'd0);
    check("rst_m1_rdata", {24'd0, m1_rdata}, 32'd0);
    check("rst_saddr",    {24'd0, saddr}, 32'd0);
    check("rst_sdatain",  {24'd0, sdatain}, 32'd0);
    check("rst_swrite",   {31'd0, SWRITE}, 32'd0);

    // Both masters request at reset release and keep re-requesting:
    // m0 reads 0x01 (0x5A), m1 reads 0x02 (0xC3), two transactions each.
    m0_we = 1'b0; m0_addr = 8'h01; m0_req = 1'b1;
    m1_we = 1'b0; m1_addr = 8'h02; m1_req = 1'b1;
    rst = 1'b0;
    n0 = 0; n1 = 0; both = 0; sw = 0; r0 = 8'h00; r1 = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) check("cont_first_saddr", {24'd0, saddr}, 32'h01);
      if (SWRITE === 1'b1) sw++;
      if (m0_ack === 1'b1 && m1_ack === 1'b1) both++;
      if (m0_ack === 1'b1) begin
        n0++; r0 = m0_rdata; ack_who.push_back(0); ack_t.push_back(i); m0_req = 1'b0;
      end else begin
        m0_req = (n0 < 2);
      end
      if (m1_ack === 1'b1) begin
        n1++; r1 = m1_rdata; ack_who.push_back(1); ack_t.push_back(i); m1_req = 1'b0;
      end else begin
        m1_req = (n1 < 2);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("cont_ack_count", ack_who.size(), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cont_ack_who%0d", k), (k < ack_who.size()) ? ack_who[k] : -1, k % 2);
      check($sformatf("cont_ack_time%0d", k), (k < ack_t.size()) ? ack_t[k] : -1, 3 + 4 * k);
    end
    check("cont_both_acks", both, 32'd0);
    check("cont_no_swrite", sw, 32'd0);
    check("cont_m0_rdata", {24'd0, r0}, 32'h5A);
    check("cont_m1_rdata", {24'd0, r1}, 32'hC3);

    // m0 write 0x10 <- 0xA5, then read it back.
    run_txn(1'b0, 1'b1, 8'h10, 8'hA5);
    check("wr_latency", lat, 32'd3);
    check("wr_swrite_cycles", wr_cycles, 32'd1);
    check("wr_saddr", {24'd0, wr_addr}, 32'h10);
    check("wr_sdatain", {24'd0, wr_data}, 32'hA5);
    check("wr_other_ack", other_ack, 32'd0);
    run_txn(1'b0, 1'b0, 8'h10, 8'h00);
    check("rd_latency", lat, 32'd3);
    check("rd_swrite_cycles", wr_cycles, 32'd0);
    check("rd_m0_rdata", {24'd0, rd}, 32'hA5);

    // m1 write, m0 rdata must hold, then m0 reads m1's data.
    run_txn(1'b1, 1'b1, 8'h30, 8'h3D);
    check("m1_wr_latency", lat, 32'd3);
    check("m1_wr_swrite_cycles", wr_cycles, 32'd1);
    check("m0_rdata_hold", {24'd0, m0_rdata}, 32'hA5);
    run_txn(1'b0, 1'b0, 8'h30, 8'h00);
    check("xrd_m0_rdata", {24'd0, rd}, 32'h3D);

    // Reset during RESP of an m1 read of 0x20: no ack, then re-request.
    m1_we = 1'b0; m1_addr = 8'h20; m1_req = 1'b1;
    tick();            // ACCESS
    tick();            // RESP
    rst = 1'b1;
    tick();            // reset edge: back in IDLE
    check("midrst_no_ack", {31'd0, m1_ack}, 32'd0);
    check("midrst_m1_rdata", {24'd0, m1_rdata}, 32'd0);
    check("midrst_m0_rdata", {24'd0, m0_rdata}, 32'd0);
    rst = 1'b0;
    lat = -1; rd = 8'hxx;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (m1_ack === 1'b1) begin
        lat = i; rd = m1_rdata;
        break;
      end
    end
    m1_req = 1'b0;
    tick();
    check("rereq_latency", lat, 32'd3);
    check("rereq_m1_rdata", {24'd0, rd}, 32'h77);

`ifdef SRAM_ARB_WPROT_EN
    // Protected m1 write is acked with error and does not reach the SRAM.
    run_txn(1'b1, 1'b1, 8'hF4, 8'h3C);
    check("prot_latency", lat, 32'd3);
    check("prot_err", {31'd0, err}, 32'd1);
    check("prot_no_swrite", wr_cycles, 32'd0);
    run_txn(1'b0, 1'b0, 8'hF4, 8'h00);
    check("prot_old_value", {24'd0, rd}, 32'h99);
    run_txn(1'b0, 1'b1, 8'hF4, 8'h55);
    check("prot_m0_swrite", wr_cycles, 32'd1);
    run_txn(1'b0, 1'b0, 8'hF4, 8'h00);
    check("prot_m0_value", {24'd0, rd}, 32'h55);
    // Just below the boundary is writable by m1 and reports no error.
    run_txn(1'b1, 1'b1, 8'hEF, 8'h12);
    check("below_base_err", {31'd0, err}, 32'd0);
    check("below_base_swrite", wr_cycles, 32'd1);
`else
    // Without protection every m1 write reaches the SRAM.
    run_txn(1'b1, 1'b1, 8'hF4, 8'h3C);
    check("noprot_swrite", wr_cycles, 32'd1);
    run_txn(1'b0, 1'b0, 8'hF4, 8'h00);
    check("noprot_value", {24'd0, rd}, 32'h3C);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
